command_credit_arbiter: RTL

- Sits between the per-source command buffers (restart, WED, write, read) and command_control.
- Picks one pending command per cycle and registers it onto the single command datapath.
- Enforces the PSL command-credit limit: credits are loaded from croom, consumed on issue and returned on each response.
- Sequences start-up and drain around `enabled`.

---
 rtl/command_credit_arbiter_pkg.sv | 26 ++
 rtl/command_credit_arbiter_round_robin.sv | 33 +++
 rtl/command_credit_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/command_credit_arbiter_pkg.sv
// Shared definitions for the command credit arbiter: requester indices,
// arbiter state encoding and the layout of the opaque command payload.
package command_credit_arbiter_pkg;

  // Requester slots on the arbiter request vector
  localparam int REQ_RESTART = 0;
  localparam int REQ_WED     = 1;
  localparam int REQ_WRITE   = 2;
  localparam int REQ_READ    = 3;

  // Arbiter sequencing around the AFU enable
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_e;

  // Command payload as carried on the command datapath (89 bits)
  typedef struct packed {
    logic [12:0] command;
    logic [63:0] address;
    logic [11:0] size;
  } cmd_payload_t;

endpackage

// File: rtl/command_credit_arbiter_round_robin.sv
// Generic round-robin picker: searches the request vector starting at the
// pointer and returns a one-hot grant plus the pointer for the next search.
module round_robin_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  input  logic             en_i,
  output logic [N-1:0]     grant_o,
  output logic [PTR_W-1:0] next_ptr_o
);

  // First requester at or after the pointer wins; pointer moves past it
  always_comb begin
    logic found;
    int   idx;
    grant_o    = '0;
    next_ptr_o = ptr_i;
    found      = 1'b0;
    idx        = 0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr_i) + off;
      if (idx >= N) idx = idx - N;
      if (en_i && !found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        next_ptr_o   = (idx == N - 1) ? '0 : PTR_W'(idx + 1);
      end
    end
  end

endmodule

// File: rtl/command_credit_arbiter.sv
// Command credit arbiter: picks one pending command per cycle, registers it
// onto the command datapath and tracks the PSL command-credit budget.
module command_credit_arbiter
  import command_credit_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int PAYLOAD_W = $bits(cmd_payload_t),
  parameter int CREDIT_W  = 8,
  parameter int PRIO0     = 1,
  parameter int SRC_W     = $clog2(NUM_REQ)
) (
  input  logic                           clock,
  input  logic                           rst,
  input  logic                           enabled,
  input  logic [CREDIT_W-1:0]            croom_in,
  input  logic                           response_valid,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*PAYLOAD_W-1:0]   req_payload,
  output logic [NUM_REQ-1:0]             req_grant,
  output logic                           cmd_valid,
  output logic [PAYLOAD_W-1:0]           cmd_payload,
  output logic [SRC_W-1:0]               cmd_source,
  output logic [CREDIT_W-1:0]            credits,
  output logic                           credit_error,
  output logic                           idle
);

  arb_state_e             state_q;
  logic [CREDIT_W-1:0]    credits_q, credits_d;
  logic [CREDIT_W-1:0]    max_credits_q;
  logic                   credit_error_q, credit_err_set;
  logic [SRC_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                   cmd_valid_q;
  logic [PAYLOAD_W-1:0]   cmd_payload_q;
  logic [SRC_W-1:0]       cmd_source_q;

  logic                   grant_en, prio_hit, rr_en, issue;
  logic [NUM_REQ-1:0]     rr_req, rr_grant;
  logic [PAYLOAD_W-1:0]   grant_payload;
  logic [SRC_W-1:0]       grant_src;
  logic [NUM_REQ-1:0][PAYLOAD_W-1:0] masked_payload;

  // Requester 0 may bypass the round-robin pool; grants need RUN and a credit
  always_comb begin
    grant_en = (state_q == ST_RUN) && (credits_q != '0);
    prio_hit = (PRIO0 != 0) && grant_en && req_valid[REQ_RESTART];
    rr_en    = grant_en && !prio_hit;
    rr_req   = req_valid;
    if (PRIO0 != 0) rr_req[REQ_RESTART] = 1'b0;
  end

  round_robin_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (SRC_W)
  ) u_rr (
    .req_i      (rr_req),
    .ptr_i      (rr_ptr_q),
    .en_i       (rr_en),
    .grant_o    (rr_grant),
    .next_ptr_o (rr_ptr_d)
  );

  // Final one-hot grant: priority slot overrides the round-robin result
  always_comb begin
    req_grant = rr_grant;
    if (prio_hit) begin
      req_grant              = '0;
      req_grant[REQ_RESTART] = 1'b1;
    end
  end

  assign issue = |req_grant;

  // Zero every payload slice except the granted one so an OR-reduce selects it
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
      assign masked_payload[gi] = req_payload[gi*PAYLOAD_W +: PAYLOAD_W]
                                  & {PAYLOAD_W{req_grant[gi]}};
    end
  endgenerate

  // Select payload and encode source index of the granted requester
  always_comb begin
    grant_payload = '0;
    grant_src     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_payload = grant_payload | masked_payload[i];
      if (req_grant[i]) grant_src = SRC_W'(i);
    end
  end

  // Credit arithmetic: issue consumes, response returns, both cancel out;
  // a response with nothing outstanding is flagged instead of counted.
  // In LOAD the counter is overwritten, so responses there are dropped.
  always_comb begin
    credits_d      = credits_q;
    credit_err_set = 1'b0;
    if (issue && !response_valid) begin
      credits_d = credits_q - CREDIT_W'(1);
    end else if (!issue && response_valid) begin
      if (credits_q == max_credits_q) credit_err_set = (state_q != ST_LOAD);
      else                            credits_d      = credits_q + CREDIT_W'(1);
    end
  end

  // Sequencer, credit registers, pointer and registered command datapath
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      credits_q      <= '0;
      max_credits_q  <= '0;
      credit_error_q <= 1'b0;
      rr_ptr_q       <= '0;
      cmd_valid_q    <= 1'b0;
      cmd_payload_q  <= '0;
      cmd_source_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE:  if (enabled) state_q <= ST_LOAD;
        ST_LOAD:  state_q <= ST_RUN;
        ST_RUN:   if (!enabled) state_q <= ST_DRAIN;
        ST_DRAIN: if (credits_q == max_credits_q) state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase

      if (state_q == ST_LOAD) begin
        credits_q     <= croom_in;
        max_credits_q <= croom_in;
      end else begin
        credits_q <= credits_d;
      end

      if (credit_err_set) credit_error_q <= 1'b1;

      if (|rr_grant) rr_ptr_q <= rr_ptr_d;

      cmd_valid_q <= issue;
      if (issue) begin
        cmd_payload_q <= grant_payload;
        cmd_source_q  <= grant_src;
      end
    end
  end

  assign cmd_valid    = cmd_valid_q;
  assign cmd_payload  = cmd_payload_q;
  assign cmd_source   = cmd_source_q;
  assign credits      = credits_q;
  assign credit_error = credit_error_q;
  assign idle         = (state_q == ST_IDLE);

endmodule
